// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: in-order register file write-back FIFO.
// Accepts results over a valid/ready handshake and drains one write per
// cycle to the register file port. A combinational lookup lets the read
// stage forward still-queued data (youngest match wins).
// Optional feature macro: WB_COALESCE_EN -- an incoming result whose address
// matches the youngest queued entry overwrites that entry in place.
module reg_writeback_queue #(
  parameter int unsigned ADD_BITS = 3,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADD_BITS-1:0]        in_addr,
  input  logic [31:0]                in_data,
  input  logic                       hold,
  output logic [ADD_BITS-1:0]        wa,
  output logic                       we,
  output logic [31:0]                wd,
  input  logic [ADD_BITS-1:0]        look_addr,
  output logic                       look_hit,
  output logic [31:0]                look_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Entry storage (not reset) and queue bookkeeping.
  logic [ADD_BITS-1:0] r_addr [DEPTH];
  logic [31:0]         r_data [DEPTH];
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [CNT_W-1:0]    r_count;

  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_coal;
  logic                w_look_hit;
  logic [31:0]         w_look_data;

  assign w_empty = (r_count == CNT_W'(0));
  assign w_full  = (r_count == CNT_W'(DEPTH));

  // A pop happens on every cycle the write port is enabled.
  assign w_pop = !w_empty && !hold && !rst;

`ifdef WB_COALESCE_EN
  logic [PTR_W-1:0] w_young;
  logic             w_coal_wr;

  // Youngest occupied slot sits just behind the tail.
  assign w_young = r_tail - PTR_W'(1);

  // Coalesce only into an entry that is not leaving this cycle.
  assign w_coal = !w_empty && (in_addr == r_addr[w_young]) &&
                  !((r_count == CNT_W'(1)) && w_pop);

  assign in_ready  = (!w_full || w_coal) && !rst;
  assign w_coal_wr = in_valid && in_ready && w_coal;
`else
  assign w_coal   = 1'b0;
  assign in_ready = !w_full && !rst;
`endif

  assign w_push = in_valid && in_ready && !w_coal;

  // Pointer and occupancy update; push and pop together leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry write: new entry at the tail, or in-place data update when coalescing.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= in_addr;
      r_data[r_tail] <= in_data;
    end
`ifdef WB_COALESCE_EN
    else if (w_coal_wr) begin
      r_data[w_young] <= in_data;
    end
`endif
  end

  // Forwarding lookup: scan oldest to youngest so the youngest match wins.
  always_comb begin
    w_look_hit  = 1'b0;
    w_look_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < r_count) &&
          (r_addr[r_head + PTR_W'(i)] == look_addr)) begin
        w_look_hit  = 1'b1;
        w_look_data = r_data[r_head + PTR_W'(i)];
      end
    end
  end

  assign look_hit  = w_look_hit;
  assign look_data = w_look_data;

  // Write port always presents the head entry; we qualifies it.
  assign we    = w_pop;
  assign wa    = r_addr[r_head];
  assign wd    = r_data[r_head];

  assign count = r_count;
  assign empty = w_empty;
  assign full  = w_full;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Scoreboard bench for reg_writeback_queue. Honors WB_COALESCE_EN when
// compiled with the same define as the design.
module tb_reg_writeback_queue;

  localparam int unsigned ADD_BITS = 3;
  localparam int unsigned DEPTH    = 4;

  typedef struct packed {
    logic [ADD_BITS-1:0] a;
    logic [31:0]         d;
  } ent_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [ADD_BITS-1:0]    in_addr;
  logic [31:0]            in_data;
  logic                   hold;
  logic [ADD_BITS-1:0]    wa;
  logic                   we;
  logic [31:0]            wd;
  logic [ADD_BITS-1:0]    look_addr;
  logic                   look_hit;
  logic [31:0]            look_data;
  logic [$clog2(DEPTH):0] count;
  logic                   empty;
  logic                   full;

  int   n_total = 0;
  int   n_bad   = 0;
  ent_t sb[$];

  reg_writeback_queue #(.ADD_BITS(ADD_BITS), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .hold      (hold),
    .wa        (wa),
    .we        (we),
    .wd        (wd),
    .look_addr (look_addr),
    .look_hit  (look_hit),
    .look_data (look_data),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: compare every cycle, then advance the scoreboard.
  always @(negedge clk) begin
    int          n;
    bit          exp_we;
    bit          coal;
    bit          exp_rdy;
    bit          hit;
    logic [31:0] ld;
    n      = sb.size();
    exp_we = !rst && !hold && (n > 0);
    coal   = 1'b0;
`ifdef WB_COALESCE_EN
    if (!rst && (n > 0) && (in_addr == sb[n-1].a) && !((n == 1) && exp_we))
      coal = 1'b1;
`endif
    exp_rdy = !rst && ((n < DEPTH) || coal);
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("we", 32'(we), 32'(exp_we));
    hit = 1'b0;
    ld  = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (sb[i].a == look_addr) begin
        hit = 1'b1;
        ld  = sb[i].d;
        break;
      end
    end
    chk("look_hit", 32'(look_hit), 32'(hit));
    chk("look_data", look_data, ld);
    if (n > 0) begin
      chk("wa_head", 32'(wa), 32'(sb[0].a));
      chk("wd_head", wd, sb[0].d);
    end
    if (exp_we) void'(sb.pop_front());
    if (rst) begin
      sb.delete();
    end else if (in_valid && exp_rdy) begin
      if (coal) sb[sb.size()-1].d = in_data;
      else      sb.push_back('{a: in_addr, d: in_data});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ADD_BITS-1:0] a, input logic [31:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  // Bounded drain: release hold and wait for the model queue to empty.
  task automatic drain();
    in_valid = 1'b0;
    hold     = 1'b0;
    for (int k = 0; k < 20 && sb.size() > 0; k++) step();
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_addr   = 3'd2;
    in_data   = 32'h1234_5678;
    hold      = 1'b0;
    look_addr = 3'd0;
    step();
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_hit", 32'(look_hit), 32'd0);
    step();

    // Single write: visible on the port the cycle after acceptance.
    push(3'd3, 32'hDEAD_BEEF);
    chk("single_we", 32'(we), 32'd1);
    chk("single_wa", 32'(wa), 32'd3);
    chk("single_wd", wd, 32'hDEAD_BEEF);
    step();
    chk("single_empty", 32'(empty), 32'd1);

    // Fill under hold, then release.
    hold = 1'b1;
    for (int i = 0; i < 4; i++) push(3'(i + 1), 32'h10 + 32'(i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ready", 32'(in_ready), 32'd0);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_we", 32'(we), 32'd0);
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rel_wa", 32'(wa), 32'(i + 1));
      chk("rel_wd", wd, 32'h10 + 32'(i));
      chk("rel_we", 32'(we), 32'd1);
      step();
    end
    drain();

    // Lookup returns the youngest match.
    hold = 1'b1;
    push(3'd5, 32'hA);
    push(3'd6, 32'hB);
    push(3'd5, 32'hC);
    look_addr = 3'd5;
    #1;
    chk("look5_hit", 32'(look_hit), 32'd1);
    chk("look5_data", look_data, 32'hC);
    look_addr = 3'd7;
    #1;
    chk("look7_hit", 32'(look_hit), 32'd0);
    chk("look7_data", look_data, 32'd0);
    drain();

    // Back-to-back stream: occupancy settles at one, no bubbles.
    hold     = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_addr = 3'(i);
      in_data = 32'h100 + 32'(i);
      step();
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_we", 32'(we), 32'd1);
    end
    in_valid = 1'b0;
    drain();

    // Full queue with youngest address 4, then offer another write to 4.
    hold = 1'b1;
    for (int i = 0; i < 4; i++) push(3'(i + 1), 32'h20 + 32'(i));
    in_valid = 1'b1;
    in_addr  = 3'd4;
    in_data  = 32'h99;
    #1;
`ifdef WB_COALESCE_EN
    chk("coal_ready", 32'(in_ready), 32'd1);
    step();
    in_valid  = 1'b0;
    look_addr = 3'd4;
    #1;
    chk("coal_count", 32'(count), 32'd4);
    chk("coal_data", look_data, 32'h99);
`else
    chk("nocoal_ready", 32'(in_ready), 32'd0);
    step();
    in_valid = 1'b0;
    #1;
    chk("nocoal_count", 32'(count), 32'd4);
`endif
    drain();

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      hold      = ($urandom_range(0, 3) == 0);
      in_addr   = 3'($urandom_range(0, 7));
      in_data   = $urandom;
      look_addr = 3'($urandom_range(0, 7));
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_writeback_queue.md
Name: reg_writeback_queue

Overview:
- Write-side initiator for the register file: accepts results (destination address and 32-bit data) from the ALU and multi-cycle units over a valid/ready handshake.
- Buffers results in a small in-order FIFO and drives the register file write port (wa, we, wd), one write per cycle.
- Provides a combinational lookup so the operand-read stage can forward data that is still queued and not yet written.

Parameters:
- ADD_BITS, 3, register address width in bits (2^ADD_BITS registers); wa, in_addr and look_addr are ADD_BITS wide.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  producer has a result.
- in_ready  output  1  queue can accept a result this cycle.
- in_addr  input  ADD_BITS  destination register.
- in_data  input  32  result value.
- hold  input  1  register file write port is busy; suppresses draining.
- wa  output  ADD_BITS  register file write address.
- we  output  1  register file write enable.
- wd  output  32  register file write data.
- look_addr  input  ADD_BITS  read-stage address to check.
- look_hit  output  1  look_addr matches a queued entry.
- look_data  output  32  data of the youngest matching entry.
- count  output  $clog2(DEPTH)+1  number of occupied entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.

Behaviour:
- Reset: synchronous. On a rising edge with rst=1, head pointer, tail pointer and count go to 0. While rst=1, in_ready=0 and we=0 (combinationally forced). After reset: empty=1, full=0, look_hit=0, count=0.
- Entry storage: addr and data per slot. Data RAM contents are not reset.
- Push: the entry is accepted when in_valid && in_ready. in_ready = !full && !rst; there is no push-while-full, even when a pop occurs in the same cycle. The entry is written at the tail and the tail advances modulo DEPTH.
- Drain: we = !empty && !hold && !rst. wa and wd equal the head entry. A pop happens on every cycle with we=1, and the head advances modulo DEPTH.
- When we=0, wa and wd still show the head entry (do-not-care for the register file).
- Latency: a result accepted in cycle N has we=1 no earlier than cycle N+1, which is its register file write edge. There is no empty-queue bypass.
- Order: writes leave in acceptance order. Duplicate addresses are written in order, so the last write wins in the register file.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- count is updated as +1 on push only, -1 on pop only, and unchanged otherwise.
- Lookup (combinational): compare look_addr with every occupied entry, including the head being written this cycle. look_hit=1 on any match. look_data = data of the youngest match (closest to the tail). With no match, look_data=0.
- hold: while held, entries are retained; pushes continue until full.

Optional Feature:
- Macro: WB_COALESCE_EN.
- When defined: if in_addr equals the address of the youngest occupied entry, and that entry is not being popped this cycle (not (count==1 && we)), the incoming data overwrites that entry's data in place. There is no push and count is unchanged.
- In the coalescing case in_ready=1 even when full: in_ready = (!full || coalesce_match) && !rst.
- When undefined: every accepted result is a new entry, and in_ready = !full && !rst.

Test Plan:
- Reset then idle: assert rst 2 cycles with in_valid=1 -> in_ready=0, we=0, count=0, empty=1 throughout and after.
- Single write: push addr 3, data 0xDEADBEEF in cycle N, hold=0 -> cycle N+1: we=1, wa=3, wd=0xDEADBEEF. Cycle N+2: empty=1.
- Fill under hold: hold=1, push addrs 1,2,3,4 with data 0x10..0x13 -> full=1, in_ready=0, count=4, we=0.
  - Then release hold -> writes 1,2,3,4 in consecutive cycles with matching data.
- Lookup youngest: hold=1, push (5,0xA), (6,0xB), (5,0xC) -> look_addr=5 gives hit=1, data 0xC. look_addr=7 gives hit=0, data 0.
- Push and pop together: continuous stream of 8 pushes with hold=0 -> count stays at 1 after the first push. Writes are in order, one per cycle, with no bubbles.
- Coalesce (macro defined): hold=1, full with youngest addr 4; push (4,0x99) -> accepted with count still 4 and youngest data 0x99.
  - Macro undefined, same stimulus -> in_ready=0.
